// File: rtl/ssp_audio_pkg.sv
// Shared types, limits and default rates for the SuperSprite audio resampler.
package ssp_audio_pkg;

  typedef logic signed [15:0] ssp_sample_t;

  localparam int SSP_SAMPLE_MAX = 32767;
  localparam int SSP_SAMPLE_MIN = -32768;
  localparam int SSP_CLK_HZ     = 54_000_000;
  localparam int SSP_SAMPLE_HZ  = 48_000;

  // Clamp a wide signed value into the 16-bit sample range.
  function automatic ssp_sample_t ssp_saturate(input logic signed [31:0] v);
    if (v > SSP_SAMPLE_MAX) begin
      return ssp_sample_t'(SSP_SAMPLE_MAX);
    end
    if (v < SSP_SAMPLE_MIN) begin
      return ssp_sample_t'(SSP_SAMPLE_MIN);
    end
    return ssp_sample_t'(v[15:0]);
  endfunction

endpackage

// File: rtl/ssp_audio_resampler_fifo.sv
// First-word-fall-through sample FIFO with a registered head and wrap-bit pointers.
module ssp_sample_fifo
  import ssp_audio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(ssp_sample_t)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_rd_next;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_do_pop};
  assign o_head    = r_head;

  // The head register tracks the entry the read pointer lands on; a write into
  // that very slot (FIFO empty after this cycle's pop) is bypassed straight in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      r_rd_ptr <= w_rd_next;
      if (w_do_push && (r_wr_ptr == w_rd_next)) begin
        r_head <= i_data;
      end else begin
        r_head <= r_mem[w_rd_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/ssp_audio_resampler.sv
// SuperSprite PSG mix to fixed-rate signed audio: low-pass, rate strobe,
// DC blocker with gain and saturation, and an output FIFO.
module ssp_audio_resampler
  import ssp_audio_pkg::*;
#(
  parameter int CLK_HZ     = SSP_CLK_HZ,
  parameter int SAMPLE_HZ  = SSP_SAMPLE_HZ,
  parameter int LPF_SHIFT  = 4,
  parameter int DCB_SHIFT  = 10,
  parameter int GAIN_SHIFT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_logic_i,
  input  logic        reset_n_i,
  input  logic [15:0] audio_i,
  input  logic        enable_i,
  output logic [15:0] sample_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        overflow_o,
  input  logic        clear_i
);

  localparam int LW = 16 + LPF_SHIFT;
  localparam int DW = 18 + DCB_SHIFT;

  logic [LW-1:0]        r_lpf;
  logic [15:0]          w_lpf_in;
  logic [15:0]          w_x;
  logic [31:0]          r_acc;
  logic [32:0]          w_acc_n;
  logic                 w_wrap;
  logic                 r_strobe;
  logic signed [DW-1:0] r_dc;
  logic signed [DW-1:0] w_dc_shift;
  logic signed [17:0]   w_d;
  logic signed [17:0]   r_d;
  logic                 r_s1_valid;
  logic signed [31:0]   w_y_wide;
  logic [15:0]          r_y;
  logic                 r_push;
  logic                 r_overflow;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_drop;

  assign w_lpf_in   = enable_i ? audio_i : 16'd0;
  assign w_x        = 16'(r_lpf >> LPF_SHIFT);
  assign w_acc_n    = {1'b0, r_acc} + 33'(SAMPLE_HZ);
  assign w_wrap     = (w_acc_n >= 33'(CLK_HZ));
  assign w_dc_shift = r_dc >>> DCB_SHIFT;
  assign w_d        = $signed({2'b00, w_x}) - 18'(w_dc_shift);
  assign w_y_wide   = $signed({{14{r_d[17]}}, r_d}) <<< GAIN_SHIFT;

  assign valid_o    = !w_empty;
  assign w_pop      = valid_o && ready_i;
  assign w_drop     = r_push && w_full && !w_pop;
  assign overflow_o = r_overflow;

  // The low-pass sum stays within LW bits because its fixed point is in << LPF_SHIFT.
  always_ff @(posedge clk_logic_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_lpf      <= '0;
      r_acc      <= '0;
      r_strobe   <= 1'b0;
      r_dc       <= '0;
      r_d        <= '0;
      r_s1_valid <= 1'b0;
      r_y        <= '0;
      r_push     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_lpf    <= r_lpf + LW'(w_lpf_in) - (r_lpf >> LPF_SHIFT);
      r_acc    <= w_wrap ? 32'(w_acc_n - 33'(CLK_HZ)) : w_acc_n[31:0];
      r_strobe <= w_wrap && enable_i;

      r_s1_valid <= r_strobe;
      if (r_strobe) begin
        r_d  <= w_d;
        r_dc <= r_dc + DW'(w_d);
      end

      r_push <= r_s1_valid;
      if (r_s1_valid) begin
        r_y <= ssp_saturate(w_y_wide);
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  ssp_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .i_clk   (clk_logic_i),
    .i_rst_n (reset_n_i),
    .i_push  (r_push),
    .i_data  (r_y),
    .i_pop   (w_pop),
    .o_head  (sample_o),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule

// File: tb/tb_ssp_audio_resampler.sv
// Directed bench: instance A (100 Hz clock, 3 Hz rate, no low-pass) for exact values,
// instance B (4-cycle sample period, default filters) for the step/DC-removal response.
module tb_ssp_audio_resampler;

  typedef struct {
    logic [15:0] audio;
    int          expSample;
    int          expCycle;
  } vec_t;

  logic        clk;
  logic        rstA_n, enA, readyA, clearA, validA, ovfA;
  logic [15:0] audioA, sampleA;
  logic        rstB_n, enB, readyB, clearB, validB, ovfB;
  logic [15:0] audioB, sampleB;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  vec_t vecs[8];
  int   expDrain[4];
  int   quietCount, idx, peak, prevS, monoBad, s1200, s3000, budget, s;

  ssp_audio_resampler #(
    .CLK_HZ(100), .SAMPLE_HZ(3), .LPF_SHIFT(0), .DCB_SHIFT(10), .GAIN_SHIFT(1), .FIFO_DEPTH(4)
  ) dutA (
    .clk_logic_i(clk), .reset_n_i(rstA_n), .audio_i(audioA), .enable_i(enA),
    .sample_o(sampleA), .valid_o(validA), .ready_i(readyA), .overflow_o(ovfA), .clear_i(clearA)
  );

  ssp_audio_resampler #(
    .CLK_HZ(100), .SAMPLE_HZ(25)
  ) dutB (
    .clk_logic_i(clk), .reset_n_i(rstB_n), .audio_i(audioB), .enable_i(enB),
    .sample_o(sampleB), .valid_o(validB), .ready_i(readyB), .overflow_o(ovfB), .clear_i(clearB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic stepCycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] audio, input logic en, input logic ready, input logic clr);
    audioA = audio;
    enA    = en;
    readyA = ready;
    clearA = clr;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected within [%0d, %0d]", name, actual, lo, hi);
    end
  endtask

  task automatic waitValidA(input int limit, input string name);
    int n = 0;
    while (!validA && n < limit) begin
      stepCycle();
      n++;
    end
    if (!validA) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: valid_o not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic restartA();
    rstA_n = 1'b0;
    @(negedge clk);
    rstA_n = 1'b1;
    cyc    = 0;
  endtask

  function automatic logic [15:0] schedAudio(input int c);
    if (c < 50)  return 16'd100;
    if (c < 85)  return 16'd200;
    if (c < 120) return 16'd300;
    if (c < 150) return 16'd400;
    return 16'd500;
  endfunction

  // Runs from reset to the cycle in which the fifth sample is pushed into a full FIFO.
  task automatic fillToFifthPush();
    applyStimulus(16'd100, 1'b1, 1'b0, 1'b0);
    restartA();
    while (cyc < 169) begin
      audioA = schedAudio(cyc);
      stepCycle();
    end
  endtask

  initial begin
    vecs[0] = '{16'd1000,  2000,   37};
    vecs[1] = '{16'd1000,  2000,   70};
    vecs[2] = '{16'd3000,  5998,  103};
    vecs[3] = '{16'd0,     -8,    137};
    vecs[4] = '{16'd20000, 32767, 170};
    vecs[5] = '{16'd0,     -48,   203};
    vecs[6] = '{16'd65535, 32767, 237};
    vecs[7] = '{16'd0,     -176,  270};
    expDrain = '{200, 400, 600, 800};

    rstA_n = 1'b0;
    rstB_n = 1'b0;
    applyStimulus(16'd500, 1'b1, 1'b0, 1'b0);
    audioB = 16'd4096; enB = 1'b1; readyB = 1'b1; clearB = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset sample_o", int'(sampleA), 0);
    checkOutput("reset valid_o", int'(validA), 0);
    checkOutput("reset overflow_o", int'(ovfA), 0);
    checkOutput("B reset valid_o", int'(validB), 0);

    // Three samples queued, then reset asserted between clock edges.
    rstA_n = 1'b1;
    cyc    = 0;
    while (cyc < 110) stepCycle();
    checkOutput("queued valid_o", int'(validA), 1);
    checkOutput("queued head", int'($signed(sampleA)), 1000);
    #2 rstA_n = 1'b0;
    #1;
    checkOutput("mid reset valid_o", int'(validA), 0);
    checkOutput("mid reset sample_o", int'(sampleA), 0);
    @(negedge clk);

    applyStimulus(vecs[0].audio, 1'b1, 1'b1, 1'b0);
    rstA_n = 1'b1;
    cyc    = 0;
    for (int i = 0; i < 8; i++) begin
      waitValidA(40, $sformatf("vec%0d wait", i));
      checkOutput($sformatf("vec%0d cycle", i), cyc, vecs[i].expCycle);
      checkOutput($sformatf("vec%0d sample", i), int'($signed(sampleA)), vecs[i].expSample);
      if (i < 7) audioA = vecs[i+1].audio;
      stepCycle();
      checkOutput($sformatf("vec%0d valid after pop", i), int'(validA), 0);
    end

    // Disabled: no samples, accumulator keeps its phase, DC state is held.
    applyStimulus(16'd1000, 1'b0, 1'b1, 1'b0);
    quietCount = 0;
    repeat (120) begin
      stepCycle();
      if (validA) quietCount++;
    end
    checkOutput("disabled sample count", quietCount, 0);
    enA = 1'b1;
    waitValidA(40, "re-enable wait");
    checkOutput("re-enable cycle", cyc, 403);
    checkOutput("re-enable sample", int'($signed(sampleA)), 1824);

    // Fifth sample dropped while clear_i is high in the same cycle.
    fillToFifthPush();
    checkOutput("pre-drop overflow_o", int'(ovfA), 0);
    checkOutput("full valid_o", int'(validA), 1);
    checkOutput("full head", int'($signed(sampleA)), 200);
    clearA = 1'b1;
    stepCycle();
    clearA = 1'b0;
    checkOutput("drop beats clear", int'(ovfA), 1);
    while (cyc < 180) stepCycle();
    checkOutput("head stable under backpressure", int'($signed(sampleA)), 200);
    readyA = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("drain%0d valid_o", k), int'(validA), 1);
      checkOutput($sformatf("drain%0d sample", k), int'($signed(sampleA)), expDrain[k]);
      stepCycle();
    end
    checkOutput("drained valid_o", int'(validA), 0);
    checkOutput("overflow sticky", int'(ovfA), 1);
    clearA = 1'b1;
    stepCycle();
    clearA = 1'b0;
    checkOutput("overflow cleared", int'(ovfA), 0);

    // Full FIFO with a pop in the push cycle: nothing lost, occupancy stays four.
    fillToFifthPush();
    readyA = 1'b1;
    checkOutput("push/pop head", int'($signed(sampleA)), 200);
    stepCycle();
    readyA = 1'b0;
    checkOutput("push/pop overflow_o", int'(ovfA), 0);
    expDrain = '{400, 600, 800, 1000};
    readyA = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("pp drain%0d valid_o", k), int'(validA), 1);
      checkOutput($sformatf("pp drain%0d sample", k), int'($signed(sampleA)), expDrain[k]);
      stepCycle();
    end
    checkOutput("pp drained valid_o", int'(validA), 0);

    // Step of 4096 into the default filters on instance B.
    rstB_n  = 1'b1;
    idx     = 0;
    peak    = -100000;
    prevS   = 0;
    monoBad = 0;
    s1200   = 0;
    s3000   = 0;
    budget  = 0;
    while (idx <= 3000 && budget < 13000) begin
      if (validB) begin
        s = int'($signed(sampleB));
        if (idx < 100 && s > peak) peak = s;
        if (idx >= 50 && s > prevS) monoBad++;
        prevS = s;
        if (idx == 1200) s1200 = s;
        if (idx == 3000) s3000 = s;
        idx++;
      end
      stepCycle();
      budget++;
    end
    checkOutput("B sample count", idx, 3001);
    checkRange("B settled peak", peak, 7500, 8192);
    checkOutput("B monotonic decay violations", monoBad, 0);
    checkRange("B sample 1200", s1200, 1000, 3011);
    checkRange("B sample 3000", s3000, 100, 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
